pack8to32: RTL and testbench



---
 rtl/pack8to32.sv | 131 +++++++++++++
 tb/tb_pack8to32.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pack8to32.sv
// Byte-to-word repacker: consumes a generator-style byte stream and emits
// little-endian 32-bit words, zero-padding a short final word.
module pack8to32 (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               _start,
    input  logic signed [31:0] count,
    input  logic               in_valid,
    input  logic signed [31:0] in_data,
    input  logic               in_done,
    output logic               in_ready,
    input  logic               _ready,
    output logic               _valid,
    output logic signed [31:0] _out0,
    output logic               _done
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] out_q, out_d;
    logic [31:0] rem_q, rem_d;
    logic [1:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    logic        slot_free;
    logic        last_byte;
    logic        accept;
    logic [31:0] word;
    logic        unused_in_data;

    assign unused_in_data = ^in_data[31:8];

    always_comb begin
        slot_free = !valid_q || _ready;
        // A byte that completes a word may only enter when the output slot can take it.
        last_byte = (idx_q == 2'd3) || (rem_q <= 32'd1);
        in_ready  = (state_q == StRun) && (!last_byte || slot_free);
        accept    = in_valid && in_ready;
        word      = acc_q | ({24'd0, in_data[7:0]} << {idx_q, 3'b000});

        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (valid_q && _ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle, StDone: begin
                if (_start) begin
                    if (count <= 0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        rem_d   = count;
                        idx_d   = 2'd0;
                        acc_d   = 32'd0;
                        done_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    rem_d = rem_q - 32'd1;
                    idx_d = idx_q + 2'd1;
                    acc_d = word;
                    if (last_byte) begin
                        out_d   = word;
                        valid_d = 1'b1;
                        idx_d   = 2'd0;
                        acc_d   = 32'd0;
                    end
                    if (rem_q == 32'd1) begin
                        state_d = StFlush;
                    end
                end else if (in_done && (idx_q == 2'd0 || slot_free)) begin
                    // Upstream ended early: push out whatever partial word is buffered.
                    if (idx_q != 2'd0) begin
                        out_d   = acc_q;
                        valid_d = 1'b1;
                        idx_d   = 2'd0;
                        acc_d   = 32'd0;
                    end
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (slot_free) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q <= StIdle;
            acc_q   <= 32'd0;
            out_q   <= 32'd0;
            rem_q   <= 32'd0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign _valid = valid_q;
    assign _out0  = out_q;
    assign _done  = done_q;

endmodule

// File: tb/tb_pack8to32.sv
// Directed bench for pack8to32: table of runs with an upstream byte source,
// downstream stall window, and a hand-written asynchronous reset sequence.
module tb_pack8to32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [31:0] count;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic               in_done;
    logic               in_ready;
    logic               ready;
    logic               valid;
    logic signed [31:0] out0;
    logic               done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pack8to32 dut (
        ._clock  (clk),
        ._reset  (rst),
        ._start  (start),
        .count   (count),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_done (in_done),
        .in_ready(in_ready),
        ._ready  (ready),
        ._valid  (valid),
        ._out0   (out0),
        ._done   (done)
    );

    typedef struct {
        int          cnt;
        int          nsend;
        logic [63:0] bytes;
        int          stall_len;
        int          nexp;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          sent       = 0;
        int          got        = 0;
        int          stall_left = 0;
        int          cyc        = 0;
        int          bi;
        bit          stall_used = 0;
        bit          ir_seen    = 0;
        bit          fin        = 0;
        bit          word_now   = 0;
        logic [31:0] exp_w;

        @(posedge clk); #1;
        count    = v.cnt;
        start    = 1'b1;
        in_valid = 1'b0;
        in_done  = 1'b0;
        ready    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (v.cnt <= 0) check({tag, "_done_immediate"}, {31'd0, done}, 32'd1);

        while (!fin && cyc < 60) begin
            bi       = (sent < 8) ? sent : 0;
            in_valid = (sent < v.nsend);
            in_data  = {24'hA5C3F0, v.bytes[8*bi +: 8]};
            in_done  = (sent >= v.nsend);
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else if (!stall_used && valid && v.stall_len > 0) begin
                stall_used = 1;
                stall_left = v.stall_len - 1;
                ready      = 1'b0;
            end else begin
                ready = 1'b1;
            end

            @(negedge clk);
            if (in_ready) ir_seen = 1;
            exp_w = (got == 0) ? v.w0 : v.w1;
            if (!ready && valid) check({tag, "_hold"}, out0, exp_w);
            if (stall_used && stall_left == 0 && !ready)
                check({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
            word_now = valid && ready;
            if (word_now) begin
                check($sformatf("%s_word%0d", tag, got), out0, exp_w);
                got++;
            end
            if (in_valid && in_ready) sent++;

            @(posedge clk); #1;
            cyc++;
            if (done) begin
                fin = 1;
                check({tag, "_done_edge"}, {31'd0, word_now}, {31'd0, v.nexp > 0});
            end
        end

        check({tag, "_finished"}, {31'd0, fin}, 32'd1);
        check({tag, "_words"}, got, v.nexp);
        check({tag, "_accepts"}, sent, v.nsend);
        check({tag, "_valid_in_done"}, {31'd0, valid}, 32'd0);
        if (v.cnt <= 0) check({tag, "_in_ready_never"}, {31'd0, ir_seen}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{8, 8, 64'h0807060504030201, 0, 2, 32'h04030201, 32'h08070605};
        vecs[1] = '{6, 6, 64'h0000161514131211, 0, 2, 32'h14131211, 32'h00001615};
        vecs[2] = '{0, 0, 64'h0, 0, 0, 32'h0, 32'h0};
        vecs[3] = '{8, 8, 64'h0807060504030201, 5, 2, 32'h04030201, 32'h08070605};
        vecs[4] = '{8, 5, 64'h0000000504030201, 0, 2, 32'h04030201, 32'h00000005};
        vecs[5] = '{-3, 0, 64'h0, 0, 0, 32'h0, 32'h0};
        vecs[6] = '{1, 1, 64'h000000000000007E, 0, 1, 32'h0000007E, 32'h0};

        rst      = 1'b1;
        start    = 1'b0;
        count    = 0;
        in_valid = 1'b0;
        in_data  = 0;
        in_done  = 1'b0;
        ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_out0", out0, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a run while a word is held and bytes are buffered.
        @(posedge clk); #1;
        count    = 8;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h00000055;
        repeat (4) @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_valid", {31'd0, valid}, 32'd1);
        check("pre_reset_out0", out0, 32'h55555555);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_valid", {31'd0, valid}, 32'd0);
        check("async_reset_out0", out0, 32'd0);
        check("async_reset_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        ready    = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_vec('{4, 4, 64'h00000000DDCCBBAA, 0, 1, 32'hDDCCBBAA, 32'h0}, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
